sump_capture_core: RTL and testbench

- Parametrised SUMP/OLS capture engine; successor to the fixed 8-channel, 8 KiB, fixed-rate capture FSM.
- Adds:
  - generic channel width and depth
  - arbitrary 24-bit divider
  - masked value trigger
  - pre/post-trigger ring buffer (SUMP read/delay counts)
  - newest-first valid/ready readback
- Sits between the SUMP command decoder (drives config and ARM) and the UART TX serialiser (consumes RD_*).

---
 rtl/sump_pkg.sv | 24 ++
 rtl/sump_sample_ram.sv | 33 +++
 rtl/sump_capture_core.sv | 227 ++++++++++++++++++++++
 tb/tb_sump_capture_core.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP capture engine: FSM states, SUMP
// command opcodes and default geometry.
package sump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_READOUT
  } sump_state_e;

  localparam logic [7:0] OP_RESET      = 8'h00;
  localparam logic [7:0] OP_ARM        = 8'h01;
  localparam logic [7:0] OP_ID         = 8'h02;
  localparam logic [7:0] OP_DIVIDER    = 8'h80;
  localparam logic [7:0] OP_RD_DLY_CNT = 8'h81;
  localparam logic [7:0] OP_TRIG_MASK  = 8'hC0;
  localparam logic [7:0] OP_TRIG_VAL   = 8'hC1;

  localparam int DEF_CH_W       = 8;
  localparam int DEF_DEPTH_LOG2 = 13;
  localparam int DEF_DIV_W      = 24;

endpackage

// File: rtl/sump_sample_ram.sv
// Simple dual-port sample memory with a registered read port; written only
// while capturing and read only during readout, so no collision handling.
module sump_sample_ram
  import sump_pkg::*;
#(
  parameter int WIDTH  = DEF_CH_W,
  parameter int ADDR_W = DEF_DEPTH_LOG2
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] r_rdata;

  // Write port: store one sample per capture strobe.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: one clock of latency, contents of the addressed slot.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sump_capture_core.sv
// SUMP/OLS capture engine: divided sample strobe, masked value trigger,
// pre/post-trigger ring buffer and newest-first valid/ready readback.
// Optional build macro SUMP_CAP_SYNC_EN adds a two-flop input synchroniser.
module sump_capture_core
  import sump_pkg::*;
#(
  parameter int CH_W       = DEF_CH_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic                  i_cap_clk,
  input  logic                  i_rst_n,
  input  logic [CH_W-1:0]       i_cap,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic [DIV_W-1:0]      i_divider,
  input  logic [CH_W-1:0]       i_trig_mask,
  input  logic [CH_W-1:0]       i_trig_val,
  input  logic [DEPTH_LOG2:0]   i_read_count,
  input  logic [DEPTH_LOG2:0]   i_delay_count,
  output logic [CH_W-1:0]       o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_busy,
  output logic                  o_triggered,
  output logic                  o_done
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  sump_state_e           r_state, w_next;
  logic [DIV_W-1:0]      r_div, r_div_cnt;
  logic [CH_W-1:0]       r_mask, r_val;
  logic [CW-1:0]         r_delay, r_rd_count, r_post_cnt, r_issue_left, r_remain;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic                  r_triggered, r_done;
  logic                  r_out_v, r_skid_v, r_pend;
  logic [CH_W-1:0]       r_out_d, r_skid_d;
  logic [CH_W-1:0]       w_cap, w_ram_q;
  logic                  w_capturing, w_strobe, w_we, w_hit, w_hs, w_issue;
  logic                  w_skid_v_next, w_arm_go, w_trig, w_enter_rd, w_finish;

`ifdef SUMP_CAP_SYNC_EN
  logic [CH_W-1:0] r_sync1, r_sync2;

  // Two-flop synchroniser; trigger and stored data share its output.
  always_ff @(posedge i_cap_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_cap;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cap = r_sync2;
`else
  assign w_cap = i_cap;
`endif

  // State register.
  always_ff @(posedge i_cap_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic plus strobe, trigger and readout-issue decisions; abort overrides all.
  always_comb begin
    w_next      = r_state;
    w_arm_go    = 1'b0;
    w_trig      = 1'b0;
    w_enter_rd  = 1'b0;
    w_finish    = 1'b0;
    w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    w_strobe    = w_capturing && (r_div_cnt == r_div);
    w_we        = w_strobe && !i_abort;
    w_hit       = ((w_cap ^ r_val) & r_mask) == '0;
    w_hs        = r_out_v && i_rd_ready;
    if (w_hs || !r_out_v) w_skid_v_next = r_skid_v && r_pend;
    else                  w_skid_v_next = r_skid_v || r_pend;
    w_issue = (r_state == ST_READOUT) && (r_issue_left != '0) && !w_skid_v_next && !i_abort;
    case (r_state)
      ST_IDLE: begin
        if (i_arm) begin
          w_arm_go = 1'b1;
          w_next   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_we && w_hit) begin
          w_trig = 1'b1;
          if (r_delay == '0) begin
            w_next     = ST_READOUT;
            w_enter_rd = 1'b1;
          end else begin
            w_next = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (w_we && (r_post_cnt == CW'(1))) begin
          w_next     = ST_READOUT;
          w_enter_rd = 1'b1;
        end
      end
      ST_READOUT: begin
        if ((r_remain == '0) || (w_hs && (r_remain == CW'(1)))) begin
          w_next   = ST_IDLE;
          w_finish = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_abort) begin
      w_next     = ST_IDLE;
      w_arm_go   = 1'b0;
      w_trig     = 1'b0;
      w_enter_rd = 1'b0;
      w_finish   = 1'b0;
    end
  end

  // Config latch at ARM, divider/write-pointer/post counters and readout counters.
  always_ff @(posedge i_cap_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div        <= '0;
      r_div_cnt    <= '0;
      r_mask       <= '0;
      r_val        <= '0;
      r_delay      <= '0;
      r_rd_count   <= '0;
      r_post_cnt   <= '0;
      r_issue_left <= '0;
      r_remain     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_arm_go) begin
        r_div       <= i_divider;
        r_mask      <= i_trig_mask;
        r_val       <= i_trig_val;
        r_delay     <= i_delay_count;
        r_rd_count  <= (i_read_count > DEPTH_CNT) ? DEPTH_CNT : i_read_count;
        r_div_cnt   <= '0;
        r_wr_ptr    <= '0;
        r_triggered <= 1'b0;
      end else if (w_capturing) begin
        r_div_cnt <= w_strobe ? '0 : r_div_cnt + DIV_W'(1);
        if (w_we) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_trig) begin
        r_triggered <= 1'b1;
        r_post_cnt  <= r_delay;
      end else if ((r_state == ST_POST) && w_we) begin
        r_post_cnt <= r_post_cnt - CW'(1);
      end
      if (i_abort) r_triggered <= 1'b0;
      if (w_enter_rd) begin
        r_rd_ptr     <= r_wr_ptr;
        r_issue_left <= r_rd_count;
        r_remain     <= r_rd_count;
      end else begin
        if (w_issue) begin
          r_rd_ptr     <= r_rd_ptr - DEPTH_LOG2'(1);
          r_issue_left <= r_issue_left - CW'(1);
        end
        if (w_hs && (r_remain != '0)) r_remain <= r_remain - CW'(1);
      end
    end
  end

  // Readout pipeline: RAM data lands in the output register, or the skid entry while stalled.
  always_ff @(posedge i_cap_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_v  <= 1'b0;
      r_out_d  <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
      r_pend   <= 1'b0;
    end else if ((r_state != ST_READOUT) || i_abort) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_hs || !r_out_v) begin
        if (r_skid_v) begin
          r_out_v  <= 1'b1;
          r_out_d  <= r_skid_d;
          r_skid_v <= r_pend;
          if (r_pend) r_skid_d <= w_ram_q;
        end else begin
          r_out_v <= r_pend;
          if (r_pend) r_out_d <= w_ram_q;
        end
      end else if (r_pend) begin
        r_skid_v <= 1'b1;
        r_skid_d <= w_ram_q;
      end
    end
  end

  sump_sample_ram #(
    .WIDTH  (CH_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (i_cap_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_cap),
    .i_re    (w_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  assign o_rd_data   = r_out_d;
  assign o_rd_valid  = r_out_v;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_triggered = r_triggered;
  assign o_done      = r_done;

endmodule

// File: tb/tb_sump_capture_core.sv
// Self-checking bench for sump_capture_core (16-deep build). A behavioural
// model tracks strobes, trigger, ring contents and newest-first readback.
module tb_sump_capture_core;

  localparam int CH_W       = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DIV_W      = 24;
  localparam int DEPTH      = 16;
`ifdef SUMP_CAP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                clk = 1'b0;
  logic                rstN;
  logic [CH_W-1:0]     cap;
  logic                arm, abortReq, rdReady;
  logic [DIV_W-1:0]    divider;
  logic [CH_W-1:0]     trigMask, trigVal;
  logic [DEPTH_LOG2:0] readCount, delayCount;
  logic [CH_W-1:0]     rdData;
  logic                rdValid, busy, triggered, done;

  int checks = 0;
  int failures = 0;

  logic [7:0] capLog[$];
  logic [7:0] mem[DEPTH];
  int         wp;

  int         cfgDiv, cfgDelay, cfgRead, capMode, readyMode;
  int         abortStep, abortRdHs, armInPost, resetInPost;
  logic [7:0] cfgMask, cfgVal;

  sump_capture_core #(
    .CH_W       (CH_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DIV_W      (DIV_W)
  ) dut (
    .i_cap_clk     (clk),
    .i_rst_n       (rstN),
    .i_cap         (cap),
    .i_arm         (arm),
    .i_abort       (abortReq),
    .i_divider     (divider),
    .i_trig_mask   (trigMask),
    .i_trig_val    (trigVal),
    .i_read_count  (readCount),
    .i_delay_count (delayCount),
    .o_rd_data     (rdData),
    .o_rd_valid    (rdValid),
    .i_rd_ready    (rdReady),
    .o_busy        (busy),
    .o_triggered   (triggered),
    .o_done        (done)
  );

  // Free-running capture clock.
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Commit the current inputs through one rising edge, return at the next falling edge.
  task automatic nextCycle();
    capLog.push_back(cap);
    @(negedge clk);
  endtask

  function automatic logic [7:0] capValue(input int step);
    case (capMode)
      0:       capValue = 8'(step - 1);
      4:       capValue = 8'($urandom) & 8'hFE;
      default: capValue = 8'($urandom);
    endcase
  endfunction

  task automatic setDefaults();
    cfgDiv = 0; cfgMask = 8'h00; cfgVal = 8'h00; cfgDelay = 0; cfgRead = 4;
    capMode = 1; readyMode = 0; abortStep = 0; abortRdHs = -1;
    armInPost = 0; resetInPost = 0;
  endtask

  task automatic abortChecks(input string tag);
    checkOutput({tag, "Busy"}, busy, 0);
    checkOutput({tag, "Valid"}, rdValid, 0);
    checkOutput({tag, "Trig"}, triggered, 0);
    checkOutput({tag, "Done"}, done, 0);
    repeat (3) begin
      nextCycle();
      checkOutput({tag, "NoDone"}, done, 0);
    end
  endtask

  // One complete run: ARM, capture until the model says readout begins, then read back.
  task automatic applyStimulus();
    int step, post, rdIdx, hsCount, n, firstValid, lastHs, bound, sidx;
    bit trig, captureDone, prevStall;
    logic [7:0] prevD, smp;
    logic [7:0] expQ[$];
    int pat[4] = '{1, 0, 0, 1};

    divider = DIV_W'(cfgDiv); trigMask = cfgMask; trigVal = cfgVal;
    delayCount = 5'(cfgDelay); readCount = 5'(cfgRead);
    arm = 1'b1;
    nextCycle();
    arm = 1'b0;
    divider = DIV_W'($urandom_range(0, 5)); trigMask = 8'($urandom); trigVal = 8'($urandom);
    delayCount = 5'($urandom); readCount = 5'($urandom);
    checkOutput("armBusy", busy, 1);
    checkOutput("armTrigClear", triggered, 0);

    wp = 0; step = 0; trig = 0; captureDone = 0; post = 0;
    while (!captureDone) begin
      step++;
      if (step > 2000) begin
        checkOutput("trigTimeout", 0, 1);
        abortReq = 1'b1; nextCycle(); abortReq = 1'b0;
        return;
      end
      cap = capValue(step);
      if (abortStep == step) begin
        abortReq = 1'b1;
        nextCycle();
        abortReq = 1'b0;
        abortChecks("abortArmed");
        return;
      end
      if (trig && armInPost != 0) arm = 1'b1;
      sidx = capLog.size();
      nextCycle();
      arm = 1'b0;
      if (step % (cfgDiv + 1) == 0) begin
        smp = capLog[sidx - LAT];
        mem[wp] = smp;
        wp = (wp + 1) % DEPTH;
        if (!trig) begin
          if (((smp ^ cfgVal) & cfgMask) == 8'h00) begin
            trig = 1;
            post = cfgDelay;
            if (post == 0) captureDone = 1;
          end
        end else begin
          post--;
          if (post == 0) captureDone = 1;
        end
      end
      checkOutput("trigFlag", triggered, trig);
      checkOutput("busyCapture", busy, 1);
      if (trig && !captureDone && resetInPost != 0 && (cfgDelay - post) >= resetInPost) begin
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstTrig", triggered, 0);
        checkOutput("rstValid", rdValid, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstData", rdData, 0);
        nextCycle();
        rstN = 1'b1;
        repeat (3) begin
          nextCycle();
          checkOutput("postRstIdle", busy, 0);
        end
        return;
      end
    end

    n = (cfgRead > DEPTH) ? DEPTH : cfgRead;
    for (int i = 0; i < n; i++) expQ.push_back(mem[(wp - 1 - i + 2 * DEPTH) % DEPTH]);
    hsCount = 0; rdIdx = 1; firstValid = 0; lastHs = 0; prevStall = 0; prevD = 8'h00;
    bound = n * 6 + 20;
    forever begin
      if (done) begin
        checkOutput("hsTotal", hsCount, n);
        checkOutput("doneValid", rdValid, 0);
        checkOutput("doneBusy", busy, 0);
        checkOutput("trigHeld", triggered, 1);
        if (n == 0) checkOutput("doneZeroIdx", rdIdx, 2);
        else        checkOutput("doneAfterLast", rdIdx, lastHs + 1);
        rdReady = 1'b0;
        nextCycle();
        checkOutput("donePulse", done, 0);
        return;
      end
      checkOutput("busyReadout", busy, 1);
      if (prevStall) begin
        checkOutput("stallValid", rdValid, 1);
        checkOutput("stallData", rdData, prevD);
      end
      if (rdValid && firstValid == 0) begin
        firstValid = rdIdx;
        checkOutput("firstValidLat", 32'(rdIdx <= 3), 1);
      end
      if (readyMode == 0 && firstValid != 0 && !rdValid && hsCount < n) checkOutput("gapless", 0, 1);
      case (readyMode)
        0:       rdReady = 1'b1;
        1:       rdReady = pat[(rdIdx - 1) % 4] != 0;
        default: rdReady = ($urandom_range(0, 1) != 0);
      endcase
      if (abortRdHs >= 0 && hsCount == abortRdHs && rdValid) begin
        rdReady = 1'b0;
        abortReq = 1'b1;
        nextCycle();
        abortReq = 1'b0;
        abortChecks("abortReadout");
        return;
      end
      if (rdValid && rdReady) begin
        if (hsCount < n) checkOutput("rdData", rdData, expQ[hsCount]);
        else             checkOutput("extraSample", hsCount, n);
        hsCount++;
        lastHs = rdIdx;
      end
      prevStall = rdValid && !rdReady;
      prevD = rdData;
      nextCycle();
      rdIdx++;
      if (rdIdx > bound) begin
        checkOutput("readTimeout", 0, 1);
        abortReq = 1'b1; nextCycle(); abortReq = 1'b0;
        return;
      end
    end
  endtask

  task automatic idleGap();
    rdReady = 1'b0;
    repeat (2) begin
      cap = 8'($urandom);
      nextCycle();
    end
  endtask

  initial begin
    rstN = 1'b0; cap = '0; arm = 1'b0; abortReq = 1'b0; rdReady = 1'b0;
    divider = '0; trigMask = '0; trigVal = '0; readCount = '0; delayCount = '0;
    nextCycle();
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetValid", rdValid, 0);
    checkOutput("resetTrig", triggered, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetData", rdData, 0);
    rstN = 1'b1;
    repeat (3) nextCycle();

    setDefaults(); capMode = 0; cfgDelay = 3; cfgRead = 4;
    applyStimulus(); idleGap();

    setDefaults(); capMode = 0; cfgDiv = 2; cfgMask = 8'h80; cfgVal = 8'h80; cfgDelay = 2;
    applyStimulus(); idleGap();

    setDefaults(); capMode = 0; cfgMask = 8'hFF; cfgVal = 8'd40; cfgRead = 20;
    applyStimulus(); idleGap();

    setDefaults(); cfgDiv = 1; cfgMask = 8'h03; cfgVal = 8'($urandom); cfgDelay = 5;
    cfgRead = 12; readyMode = 1;
    applyStimulus(); idleGap();

    setDefaults(); capMode = 4; cfgMask = 8'h01; cfgVal = 8'h01; abortStep = 6;
    applyStimulus(); idleGap();

    setDefaults(); cfgDelay = 4; cfgRead = 6;
    applyStimulus(); idleGap();

    setDefaults(); cfgDelay = 8; cfgRead = 8; abortRdHs = 3;
    applyStimulus(); idleGap();

    setDefaults(); cfgDiv = 1; cfgDelay = 10; cfgRead = 5; resetInPost = 3;
    applyStimulus(); idleGap();

    setDefaults(); cfgDiv = 1; cfgDelay = 6; cfgRead = 7; armInPost = 1; readyMode = 2;
    applyStimulus(); idleGap();

    setDefaults(); cfgDelay = 2; cfgRead = 0;
    applyStimulus(); idleGap();

    for (int r = 0; r < 10; r++) begin
      setDefaults();
      cfgDiv    = $urandom_range(0, 3);
      cfgMask   = 8'($urandom & $urandom) & 8'h3F;
      cfgVal    = 8'($urandom);
      cfgDelay  = $urandom_range(0, 20);
      cfgRead   = $urandom_range(0, 20);
      readyMode = $urandom_range(0, 2);
      applyStimulus(); idleGap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
